// File: rtl/adc_pkg.sv
// Shared state encoding and counter widths for the ADC capture controller.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } adc_state_e;

   localparam int WRAP_CNT_WIDTH = 8;

endpackage

// File: rtl/adc_ring_ptr.sv
// Modulo-length offset counter for the capture ring buffer.
// Reports a wrap pulse on the advance that returns it to 0, and the physical RAM address.
module adc_ring_ptr #(
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   input  logic                     adv_i,
   input  logic [ADDRESS_WIDTH-1:0] len_i,
   input  logic [ADDRESS_WIDTH-1:0] base_i,
   output logic [ADDRESS_WIDTH-1:0] ptr_o,
   output logic [ADDRESS_WIDTH-1:0] addr_o,
   output logic                     wrap_o
);

   logic [ADDRESS_WIDTH-1:0] ptr_q;
   logic [ADDRESS_WIDTH-1:0] ptr_d;
   logic                     at_last;

   // len_i is never 0 while advancing, so len_i-1 is always a valid offset here
   assign at_last = (ptr_q == (len_i - 1'b1));
   assign wrap_o  = adv_i && at_last;

   always_comb begin
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = '0;
      end else if (adv_i) begin
         ptr_d = at_last ? '0 : (ptr_q + 1'b1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Truncation to ADDRESS_WIDTH lets a buffer straddle the top of RAM
   assign addr_o = base_i + ptr_q;
   assign ptr_o  = ptr_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arms on start, optionally waits for a trigger, then writes
// every (decim+1)th valid sample into consecutive ring-buffer words of the data RAM.
module adc_capture_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int SAMPLE_WIDTH  = 12,
   parameter int DECIM_WIDTH   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   input  logic [ADDRESS_WIDTH-1:0]  cfg_base,
   input  logic [ADDRESS_WIDTH-1:0]  cfg_len,
   input  logic                      cfg_cont,
   input  logic                      cfg_trig_en,
   input  logic [DECIM_WIDTH-1:0]    cfg_decim,
   input  logic                      trig,
   input  logic                      sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]   sample_data,
   output logic                      adc_wEn,
   output logic [ADDRESS_WIDTH-1:0]  adc_addr,
   output logic [DATA_WIDTH-1:0]     adc_dataIn,
   output logic                      busy,
   output logic                      done,
   output logic [ADDRESS_WIDTH-1:0]  wr_ptr,
   output logic [WRAP_CNT_WIDTH-1:0] wrap_cnt
);

   adc_state_e                state_q, state_d;

   logic [ADDRESS_WIDTH-1:0]  base_q;
   logic [ADDRESS_WIDTH-1:0]  len_q;
   logic                      cont_q;
   logic [DECIM_WIDTH-1:0]    decim_q;

   logic [DECIM_WIDTH-1:0]    dcnt_q, dcnt_d;
   logic [WRAP_CNT_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;

   logic                      wen_q;
   logic [ADDRESS_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      busy_q, done_q;

   logic                      ld_cfg;
   logic                      clr_dcnt;
   logic                      accept;
   logic                      ring_wrap;
   logic [ADDRESS_WIDTH-1:0]  ring_addr;
   logic [ADDRESS_WIDTH-1:0]  ring_ptr;

   assign accept = (state_q == CAPTURE) && sample_valid && (dcnt_q == '0);

   adc_ring_ptr #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_ring_ptr (
      .clk_i  (clk),
      .reset_i(reset),
      .clear_i(ld_cfg),
      .adv_i  (accept),
      .len_i  (len_q),
      .base_i (base_q),
      .ptr_o  (ring_ptr),
      .addr_o (ring_addr),
      .wrap_o (ring_wrap)
   );

   // Stop takes priority over trigger and wrap; start only counts when not busy
   always_comb begin
      state_d = state_q;
      ld_cfg  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ld_cfg = 1'b1;
               if (cfg_len == '0) begin
                  state_d = DONE;
               end else if (cfg_trig_en) begin
                  state_d = ARMED;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         ARMED: begin
            if (stop) begin
               state_d = DONE;
            end else if (trig) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (stop || (ring_wrap && !cont_q)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr_dcnt = (state_d == CAPTURE) && (state_q != CAPTURE);

   always_comb begin
      dcnt_d = dcnt_q;
      if (ld_cfg || clr_dcnt) begin
         dcnt_d = '0;
      end else if ((state_q == CAPTURE) && sample_valid) begin
         dcnt_d = (dcnt_q == decim_q) ? '0 : (dcnt_q + 1'b1);
      end
   end

   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (ld_cfg) begin
         wrap_cnt_d = '0;
      end else if (ring_wrap && cont_q && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
   end

   always_comb begin
      data_d                   = '0;
      data_d[SAMPLE_WIDTH-1:0] = sample_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dcnt_q     <= '0;
         wrap_cnt_q <= '0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dcnt_q     <= dcnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         wen_q      <= accept;
         if (accept) begin
            addr_q <= ring_addr;
            data_q <= data_d;
         end
         busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
         done_q     <= (state_d == DONE);
      end
   end

   // Configuration is only meaningful after a start, so it needs no reset
   always_ff @(posedge clk) begin
      if (ld_cfg) begin
         base_q  <= cfg_base;
         len_q   <= cfg_len;
         cont_q  <= cfg_cont;
         decim_q <= cfg_decim;
      end
   end

   assign adc_wEn    = wen_q;
   assign adc_addr   = addr_q;
   assign adc_dataIn = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign wr_ptr     = ring_ptr;
   assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed, table-driven bench for adc_capture_ctrl: one record per clock cycle.
module tb_adc_capture_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, stop, cfg_cont, cfg_trig_en, trig, sample_valid;
   logic [11:0] cfg_base, cfg_len, sample_data;
   logic [7:0]  cfg_decim;
   logic        adc_wEn, busy, done;
   logic [11:0] adc_addr, wr_ptr;
   logic [31:0] adc_dataIn;
   logic [7:0]  wrap_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rst, st, sp;
      logic [11:0] base, len;
      logic        cont, ten;
      logic [7:0]  dec;
      logic        tg, v;
      logic [11:0] d;
      logic        e_we;
      logic [11:0] e_addr;
      logic [31:0] e_data;
      logic        e_busy, e_done;
      logic [11:0] e_ptr;
      logic [7:0]  e_wrap;
   } vec_t;

   vec_t        vq[$];
   logic [11:0] c_base, c_len;
   logic        c_cont, c_ten;
   logic [7:0]  c_dec;

   always #5 clk = ~clk;

   adc_capture_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_cont(cfg_cont),
      .cfg_trig_en(cfg_trig_en), .cfg_decim(cfg_decim), .trig(trig),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .adc_wEn(adc_wEn), .adc_addr(adc_addr), .adc_dataIn(adc_dataIn),
      .busy(busy), .done(done), .wr_ptr(wr_ptr), .wrap_cnt(wrap_cnt)
   );

   task automatic cfg(input logic [11:0] b, input logic [11:0] l, input logic c,
                      input logic t, input logic [7:0] dc);
      c_base = b; c_len = l; c_cont = c; c_ten = t; c_dec = dc;
   endtask

   // Expected write data is the row's own sample zero-extended (zero in a reset row)
   task automatic add(input logic rst, input logic st, input logic sp, input logic tg,
                      input logic v, input logic [11:0] d, input logic we,
                      input logic [11:0] addr, input logic bsy, input logic dn,
                      input logic [11:0] ptr, input logic [7:0] wr);
      vec_t r;
      r.rst = rst; r.st = st; r.sp = sp;
      r.base = c_base; r.len = c_len; r.cont = c_cont; r.ten = c_ten; r.dec = c_dec;
      r.tg = tg; r.v = v; r.d = d;
      r.e_we = we; r.e_addr = addr; r.e_data = rst ? 32'h0 : {20'h0, d};
      r.e_busy = bsy; r.e_done = dn; r.e_ptr = ptr; r.e_wrap = wr;
      vq.push_back(r);
   endtask

   task automatic chk(input int idx, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t r, input int idx);
      reset = r.rst; start = r.st; stop = r.sp;
      cfg_base = r.base; cfg_len = r.len; cfg_cont = r.cont;
      cfg_trig_en = r.ten; cfg_decim = r.dec;
      trig = r.tg; sample_valid = r.v; sample_data = r.d;
      @(posedge clk);
      #1;
      chk(idx, "wEn",      {31'b0, adc_wEn}, {31'b0, r.e_we});
      chk(idx, "busy",     {31'b0, busy},    {31'b0, r.e_busy});
      chk(idx, "done",     {31'b0, done},    {31'b0, r.e_done});
      chk(idx, "wr_ptr",   {20'b0, wr_ptr},  {20'b0, r.e_ptr});
      chk(idx, "wrap_cnt", {24'b0, wrap_cnt}, {24'b0, r.e_wrap});
      if (r.e_we || r.rst) begin
         chk(idx, "addr", {20'b0, adc_addr}, {20'b0, r.e_addr});
         chk(idx, "data", adc_dataIn, r.e_data);
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0;
      sample_valid = 1'b0; sample_data = '0;
      cfg_base = '0; cfg_len = '0; cfg_cont = 1'b0; cfg_trig_en = 1'b0; cfg_decim = '0;
      cfg(12'h000, 12'd0, 0, 0, 8'd0);

      //   rst st sp tg v  d        we addr     bsy dn ptr wrap
      add(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0);
      // One-shot, 6 back-to-back valids
      cfg(12'h100, 12'd4, 0, 0, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h001, 1, 12'h100, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'h002, 1, 12'h101, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'h003, 1, 12'h102, 1, 0, 3, 0);
      add(0, 0, 0, 0, 1, 12'h004, 1, 12'h103, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 12'h005, 0, 12'h000, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 12'h006, 0, 12'h000, 0, 1, 0, 0);
      // Continuous ring of 3
      cfg(12'h200, 12'd3, 1, 0, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h021, 1, 12'h200, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'h022, 1, 12'h201, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'h023, 1, 12'h202, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 12'h024, 1, 12'h200, 1, 0, 1, 1);
      add(0, 0, 0, 0, 1, 12'h025, 1, 12'h201, 1, 0, 2, 1);
      add(0, 0, 0, 0, 1, 12'h026, 1, 12'h202, 1, 0, 0, 2);
      add(0, 0, 0, 0, 1, 12'h027, 1, 12'h200, 1, 0, 1, 2);
      add(0, 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 1, 2);
      // Decimation by 3: samples 10..18, keep 10, 13, 16
      cfg(12'h300, 12'd8, 0, 0, 8'd2);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'd10,  1, 12'h300, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'd11,  0, 12'h000, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'd12,  0, 12'h000, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'd13,  1, 12'h301, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'd14,  0, 12'h000, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'd15,  0, 12'h000, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'd16,  1, 12'h302, 1, 0, 3, 0);
      add(0, 0, 0, 0, 1, 12'd17,  0, 12'h000, 1, 0, 3, 0);
      add(0, 0, 0, 0, 1, 12'd18,  0, 12'h000, 1, 0, 3, 0);
      add(0, 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 3, 0);
      // Trigger, buffer straddling top of RAM
      cfg(12'hFFE, 12'd4, 0, 1, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h041, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h042, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 1, 1, 12'h043, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h044, 1, 12'hFFE, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'h045, 1, 12'hFFF, 1, 0, 2, 0);
      add(0, 0, 0, 0, 1, 12'h046, 1, 12'h000, 1, 0, 3, 0);
      add(0, 0, 0, 0, 1, 12'h047, 1, 12'h001, 0, 1, 0, 0);
      // Stop with a write accepted in the same cycle; stop in DONE ignored
      cfg(12'h050, 12'd10, 0, 0, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h051, 1, 12'h050, 1, 0, 1, 0);
      add(0, 0, 1, 0, 1, 12'h052, 1, 12'h051, 0, 1, 2, 0);
      add(0, 0, 0, 0, 1, 12'h053, 0, 12'h000, 0, 1, 2, 0);
      add(0, 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 2, 0);
      // Start while busy is ignored (config not relatched); start+stop while busy -> stop
      cfg(12'h060, 12'd5, 0, 0, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      cfg(12'h700, 12'd2, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1, 12'h061, 1, 12'h060, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 12'h062, 1, 12'h061, 1, 0, 2, 0);
      add(0, 1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 2, 0);
      // Start+stop in DONE -> start wins
      cfg(12'h070, 12'd2, 0, 0, 8'd0);
      add(0, 1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1, 0, 0);
      // Zero length: straight to DONE, no writes
      cfg(12'h080, 12'd0, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1, 12'h081, 0, 12'h000, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 12'h082, 0, 12'h000, 0, 1, 0, 0);
      // Reset in CAPTURE with a valid present: no write afterwards
      cfg(12'h090, 12'd4, 1, 0, 8'd0);
      add(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h091, 1, 12'h090, 1, 0, 1, 0);
      add(1, 0, 0, 0, 1, 12'h092, 0, 12'h000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 12'h093, 0, 12'h000, 0, 0, 0, 0);

      @(negedge clk);
      foreach (vq[i]) apply(vq[i], i);

      // wrap_cnt saturation: len=1 continuous, every accepted sample wraps
      start = 1'b1; stop = 1'b0; trig = 1'b0; sample_valid = 1'b0;
      cfg_base = 12'h3FF; cfg_len = 12'd1; cfg_cont = 1'b1; cfg_trig_en = 1'b0; cfg_decim = '0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         sample_valid = 1'b1;
         sample_data  = 12'(i);
         @(posedge clk);
         @(negedge clk);
      end
      chk(1000, "sat_wrap_cnt", {24'b0, wrap_cnt}, 32'd255);
      chk(1000, "sat_wr_ptr",   {20'b0, wr_ptr},   32'd0);
      chk(1000, "sat_busy",     {31'b0, busy},     32'd1);
      chk(1000, "sat_wEn",      {31'b0, adc_wEn},  32'd1);
      chk(1000, "sat_addr",     {20'b0, adc_addr}, 32'h3FF);
      chk(1000, "sat_data",     adc_dataIn,        32'd299);
      sample_valid = 1'b0;
      stop = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stop = 1'b0;
      chk(1001, "sat_stop_done", {31'b0, done},     32'd1);
      chk(1001, "sat_stop_wrap", {24'b0, wrap_cnt}, 32'd255);
      chk(1001, "sat_stop_wEn",  {31'b0, adc_wEn},  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
